iob_initiator: RTL and testbench
================================

# iob_initiator

CPU-side initiator for the internal I/O bus. It accepts a decoded I/O access from the 68030 bus logic and launches one I/O-bus transaction toward the PDS bus master. It drives the request, strobes, direction and address/data latch enable. It tracks the master's IOACT busy flag through a synchronizer and returns a single-cycle ACK (or BERR on timeout) so the CPU can terminate its bus cycle.

## Interface
Parameters:
- SYNC_STAGES, 2, number of flops synchronizing IOACT into CLK domain (legal 2..3)
- TIMEOUT, 1023, cycles allowed in REQ+ACT before bus error (fits 10-bit counter)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RES  in  1  reset, synchronous, active-high
- CPUREQ  in  1  level; decoded I/O access pending from CPU bus logic
- CPUWE  in  1  1 = write, valid while CPUREQ
- CPULDS  in  1  lower byte strobe request, valid while CPUREQ
- CPUUDS  in  1  upper byte strobe request, valid while CPUREQ
- ACK  out  1  one-cycle pulse: transaction complete, CPU may terminate
- BERR  out  1  one-cycle pulse: transaction timed out
- IOREQ  out  1  request to PDS bus master
- IOWE  out  1  write direction to master
- IOLDS  out  1  lower strobe to master
- IOUDS  out  1  upper strobe to master
- nADLEEN  out  1  active-low; opens PDS address/data output latch
- IOACT  in  1  master busy flag, asynchronous to CLK

## Operation
- IOACTs = IOACT after SYNC_STAGES flops; FSM uses only IOACTs.
- Reset values: state IDLE; ACK=0, BERR=0, IOREQ=0, IOWE=0, IOLDS=0, IOUDS=0, nADLEEN=1; counter 0; sync flops 0.
- IDLE: if CPUREQ && !IOACTs -> REQ. On that edge register IOWE<=CPUWE, IOLDS<=CPULDS, IOUDS<=CPUUDS, IOREQ<=1, nADLEEN<=0, counter<=0. If IOACTs is high, stay in IDLE and wait for the master to finish a stale cycle.
- REQ: counter++. If IOACTs -> ACT with IOREQ<=0 and nADLEEN<=1; the master holds its latch itself from then on.
- ACT: counter++. If !IOACTs -> TERM.
- TERM: ACK=1 for exactly this cycle. Clear IOWE/IOLDS/IOUDS. -> REARM.
- REARM: wait for !CPUREQ, then -> IDLE. A still-asserted CPUREQ never launches a second transaction.
- Timeout: in REQ or ACT, if counter==TIMEOUT-1 on an edge where the normal transition is not taken, go to ERR. Set IOREQ<=0 and nADLEEN<=1.
- ERR: BERR=1 for exactly this cycle; clear strobes/IOWE. -> DRAIN.
- DRAIN: wait for !IOACTs, then -> REARM.
- Both strobes 0 with CPUREQ: the transaction still runs (master issues AS only); ACK as normal.
- CPUREQ dropping mid-transaction (REQ/ACT): the transaction completes. ACK/BERR still pulse, and the CPU side ignores them. REARM then passes straight to IDLE.
- Timeout and normal transition on the same edge: the normal transition wins.
- RES mid-transaction: all outputs return to reset values next edge, IOREQ drops immediately. After reset the block waits in IDLE for !IOACTs before starting a new request.
- IOWE/IOLDS/IOUDS are stable from the REQ entry edge through ACT. They change only at TERM/ERR.

## Timing
- Outputs are registered; none are combinational from inputs.
- Launch latency: CPUREQ sampled high at edge n gives IOREQ=1 after edge n.
- IOREQ falls SYNC_STAGES+1 edges after IOACT rises, or SYNC_STAGES+2 worst case with asynchronous phase. This must precede the master's return to idle: the master spends at least 2 of its cycles in post-DTACK states.
- ACK asserts SYNC_STAGES+1 edges after IOACT falls, for 1 cycle.
- Minimum spacing between consecutive IOREQ assertions: 3 CLK cycles (TERM, REARM, IDLE).
- Counter is 10 bits wide and saturates; it never wraps.

## Test plan
- Read, SYNC_STAGES=2: CPUREQ=1, CPUWE=0, LDS=UDS=1. Model raises IOACT 3 cycles after IOREQ and drops it 12 cycles later. Required: IOREQ high 1 edge after CPUREQ, low 3 edges after IOACT rise. Single ACK pulse 3 edges after IOACT fall. BERR=0.
- Byte write: CPUWE=1, LDS=1, UDS=0. Required: IOWE=1, IOLDS=1, IOUDS=0 for the whole cycle; nADLEEN low from launch until IOACTs seen high; one ACK.
- CPUREQ held high 20 cycles after ACK: exactly one IOREQ assertion. Dropping CPUREQ for 1 cycle then re-raising it launches a second transaction with spacing of at least 3 cycles.
- Timeout, TIMEOUT=16: IOACT never rises. Required: IOREQ drops at count 16, one BERR pulse, no ACK. With IOACT then held high 5 more cycles, no new IOREQ until IOACTs low.
- RES asserted in ACT: next edge IOREQ=0, nADLEEN=1, strobes 0, no ACK/BERR. With IOACT still high, CPUREQ=1 gets no IOREQ until IOACTs=0.
- Stale busy: IOACT=1 at idle with CPUREQ=1. No IOREQ until IOACT falls, then launch after SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/iob_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_initiator_if
// Description : CPU-side access request and PDS bus-master handshake signals
// Revision    : 1.0  initial release
// ============================================================================
interface iob_initiator_if;
    logic CPUREQ;
    logic CPUWE;
    logic CPULDS;
    logic CPUUDS;
    logic ACK;
    logic BERR;
    logic IOREQ;
    logic IOWE;
    logic IOLDS;
    logic IOUDS;
    logic nADLEEN;
    logic IOACT;

    // master: the initiator itself; slave: CPU bus logic plus PDS bus master
    modport master (
        input  CPUREQ, CPUWE, CPULDS, CPUUDS, IOACT,
        output ACK, BERR, IOREQ, IOWE, IOLDS, IOUDS, nADLEEN
    );

    modport slave (
        output CPUREQ, CPUWE, CPULDS, CPUUDS, IOACT,
        input  ACK, BERR, IOREQ, IOWE, IOLDS, IOUDS, nADLEEN
    );
endinterface
`default_nettype wire

// File: rtl/iob_initiator.sv
`default_nettype none
// ============================================================================
// Module      : iob_initiator
// Description : Launches one I/O-bus transaction per CPU access, returns ACK/BERR
// Revision    : 1.0  initial release
// ============================================================================
module iob_initiator #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic           CLK,
    input  logic           RES,
    iob_initiator_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ACT   = 3'd2,
        S_TERM  = 3'd3,
        S_REARM = 3'd4,
        S_ERR   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    localparam logic [9:0] c_TIMEOUT_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] c_COUNT_MAX    = 10'h3FF;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ioactSync;
    logic [SYNC_STAGES-1:0] r_primed;
    logic [9:0]             r_count;
    logic                   r_ack;
    logic                   r_berr;
    logic                   r_ioReq;
    logic                   r_ioWe;
    logic                   r_ioLds;
    logic                   r_ioUds;
    logic                   r_nAdleEn;

    logic       w_ioactS;
    logic       w_launchOk;
    logic       w_timeout;
    logic [9:0] w_countInc;

    assign w_ioactS   = r_ioactSync[SYNC_STAGES-1];
    // The synchronizer restarts from zero on reset, so IOACTs is meaningless
    // until it has refilled; no launch is allowed before then.
    assign w_launchOk = r_primed[SYNC_STAGES-1];
    assign w_timeout  = (r_count == c_TIMEOUT_LAST);
    assign w_countInc = (r_count == c_COUNT_MAX) ? r_count : r_count + 10'd1;

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state     <= S_IDLE;
            r_ioactSync <= '0;
            r_primed    <= '0;
            r_count     <= '0;
            r_ack       <= 1'b0;
            r_berr      <= 1'b0;
            r_ioReq     <= 1'b0;
            r_ioWe      <= 1'b0;
            r_ioLds     <= 1'b0;
            r_ioUds     <= 1'b0;
            r_nAdleEn   <= 1'b1;
        end else begin
            r_ioactSync <= {r_ioactSync[SYNC_STAGES-2:0], bus.IOACT};
            r_primed    <= {r_primed[SYNC_STAGES-2:0], 1'b1};
            r_ack       <= 1'b0;
            r_berr      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.CPUREQ && !w_ioactS && w_launchOk) begin
                        r_state   <= S_REQ;
                        r_ioWe    <= bus.CPUWE;
                        r_ioLds   <= bus.CPULDS;
                        r_ioUds   <= bus.CPUUDS;
                        r_ioReq   <= 1'b1;
                        r_nAdleEn <= 1'b0;
                        r_count   <= '0;
                    end
                end
                S_REQ: begin
                    r_count <= w_countInc;
                    // The normal transition takes priority over a coincident timeout.
                    if (w_ioactS) begin
                        r_state   <= S_ACT;
                        r_ioReq   <= 1'b0;
                        r_nAdleEn <= 1'b1;
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_ioReq   <= 1'b0;
                        r_nAdleEn <= 1'b1;
                        r_berr    <= 1'b1;
                        r_ioWe    <= 1'b0;
                        r_ioLds   <= 1'b0;
                        r_ioUds   <= 1'b0;
                    end
                end
                S_ACT: begin
                    r_count <= w_countInc;
                    if (!w_ioactS) begin
                        r_state <= S_TERM;
                        r_ack   <= 1'b1;
                        r_ioWe  <= 1'b0;
                        r_ioLds <= 1'b0;
                        r_ioUds <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_ioReq   <= 1'b0;
                        r_nAdleEn <= 1'b1;
                        r_berr    <= 1'b1;
                        r_ioWe    <= 1'b0;
                        r_ioLds   <= 1'b0;
                        r_ioUds   <= 1'b0;
                    end
                end
                S_TERM: begin
                    r_state <= S_REARM;
                end
                S_REARM: begin
                    if (!bus.CPUREQ) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!w_ioactS) begin
                        r_state <= S_REARM;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ACK     = r_ack;
    assign bus.BERR    = r_berr;
    assign bus.IOREQ   = r_ioReq;
    assign bus.IOWE    = r_ioWe;
    assign bus.IOLDS   = r_ioLds;
    assign bus.IOUDS   = r_ioUds;
    assign bus.nADLEEN = r_nAdleEn;

endmodule
`default_nettype wire

// File: tb/tb_iob_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_initiator
// Description : Scoreboard bench for iob_initiator (normal and timeout builds)
// Revision    : 1.0  initial release
// ============================================================================
module tb_iob_initiator;

    logic CLK = 1'b0;
    logic RES = 1'b1;
    always #5 CLK = ~CLK;

    iob_initiator_if busA ();
    iob_initiator_if busB ();

    iob_initiator #(.SYNC_STAGES(2), .TIMEOUT(1023)) dutA (.CLK(CLK), .RES(RES), .bus(busA));
    iob_initiator #(.SYNC_STAGES(2), .TIMEOUT(16))   dutB (.CLK(CLK), .RES(RES), .bus(busB));

    wire [6:0] outA = {busA.ACK, busA.BERR, busA.IOREQ, busA.IOWE, busA.IOLDS, busA.IOUDS, busA.nADLEEN};
    wire [6:0] outB = {busB.ACK, busB.BERR, busB.IOREQ, busB.IOWE, busB.IOLDS, busB.IOUDS, busB.nADLEEN};

    typedef struct packed {
        logic       err;
        logic [2:0] strb;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] obsStrb;
    logic [2:0] curStrb;
    int         checkCnt = 0;
    int         passCnt  = 0;
    int         cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        busA.CPUREQ = 0; busA.CPUWE = 0; busA.CPULDS = 0; busA.CPUUDS = 0; busA.IOACT = 0;
        busB.CPUREQ = 0; busB.CPUWE = 0; busB.CPULDS = 0; busB.CPUUDS = 0; busB.IOACT = 0;
        RES = 1;
        tick(); tick();
        checkCnt++; if (outA !== 7'b0000001) $display("FAIL reset_A: got %b want %b", outA, 7'b0000001); else passCnt++;
        checkCnt++; if (outB !== 7'b0000001) $display("FAIL reset_B: got %b want %b", outB, 7'b0000001); else passCnt++;
        RES = 0;
        tick(); tick(); tick();
        checkCnt++; if (outA !== 7'b0000001) $display("FAIL idle_after_reset: got %b want %b", outA, 7'b0000001); else passCnt++;
    endtask

    // Raise CPUREQ and count edges until IOREQ appears; push the expected result.
    task automatic launch(input logic we, input logic lds, input logic uds, input int expLat);
        int n;
        n = 0;
        busA.CPUWE = we; busA.CPULDS = lds; busA.CPUUDS = uds; busA.CPUREQ = 1;
        for (int i = 1; i <= expLat + 4; i++) begin
            if (n == 0) begin
                tick();
                if (busA.IOREQ === 1'b1) n = i;
            end
        end
        checkCnt++; if (n !== expLat) $display("FAIL launch_latency: got %0d want %0d", n, expLat); else passCnt++;
        checkCnt++; if (busA.nADLEEN !== 1'b0) $display("FAIL adle_open: got %b want 0", busA.nADLEEN); else passCnt++;
        curStrb = {we, lds, uds};
        obsStrb = {busA.IOWE, busA.IOLDS, busA.IOUDS};
        sb.push_back('{err: 1'b0, strb: {we, lds, uds}});
    endtask

    task automatic complete(input int actDelay, input int actLen, input bit dropReq, output int ackCyc);
        int   n;
        logic bad;
        exp_t e;
        bad = 0;
        for (int i = 0; i < actDelay; i++) begin
            tick();
            if ({busA.IOWE, busA.IOLDS, busA.IOUDS} !== curStrb || busA.IOREQ !== 1'b1 || busA.nADLEEN !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL req_phase: got %b want strb %b req 1 adle 0", outA, curStrb); else passCnt++;
        busA.IOACT = 1;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            if (n == 0) begin
                tick();
                if (busA.IOREQ === 1'b0) n = i;
            end
        end
        checkCnt++; if (n !== 3) $display("FAIL ioreq_fall: got %0d want 3", n); else passCnt++;
        checkCnt++; if (busA.nADLEEN !== 1'b1) $display("FAIL adle_close: got %b want 1", busA.nADLEEN); else passCnt++;
        bad = 0;
        for (int i = n + 1; i <= actLen; i++) begin
            tick();
            if ({busA.IOWE, busA.IOLDS, busA.IOUDS} !== curStrb || busA.ACK !== 1'b0 || busA.BERR !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL act_phase: got %b want strb %b no ack", outA, curStrb); else passCnt++;
        busA.IOACT = 0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (n == 0) begin
                tick();
                if (busA.ACK === 1'b1 || busA.BERR === 1'b1) n = i;
            end
        end
        ackCyc = cyc;
        checkCnt++; if (n !== 3) $display("FAIL ack_latency: got %0d want 3", n); else passCnt++;
        checkCnt++;
        if (sb.size() == 0) $display("FAIL sb_empty: got 0 entries want 1");
        else begin
            e = sb.pop_front();
            if (busA.BERR !== e.err || obsStrb !== e.strb)
                $display("FAIL sb_result: got berr %b strb %b want berr %b strb %b", busA.BERR, obsStrb, e.err, e.strb);
            else passCnt++;
        end
        tick();
        checkCnt++; if ({busA.ACK, busA.BERR} !== 2'b00) $display("FAIL ack_pulse: got %b want 00", {busA.ACK, busA.BERR}); else passCnt++;
        if (dropReq) begin
            busA.CPUREQ = 0;
            tick(); tick();
        end
    endtask

    task automatic test_read();
        int a;
        launch(1'b0, 1'b1, 1'b1, 1);
        complete(3, 12, 1'b1, a);
    endtask

    task automatic test_byte_write();
        int a;
        launch(1'b1, 1'b1, 1'b0, 1);
        complete(3, 6, 1'b1, a);
        launch(1'b0, 1'b0, 1'b0, 1);
        complete(2, 4, 1'b1, a);
    endtask

    task automatic test_back_to_back();
        int   a;
        int   rises;
        logic prev;
        launch(1'b0, 1'b1, 1'b1, 1);
        complete(3, 5, 1'b0, a);
        rises = 0;
        prev  = busA.IOREQ;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busA.IOREQ === 1'b1 && prev !== 1'b1) rises++;
            prev = busA.IOREQ;
        end
        checkCnt++; if (rises !== 0) $display("FAIL held_req_relaunch: got %0d want 0", rises); else passCnt++;
        busA.CPUREQ = 0;
        tick();
        launch(1'b1, 1'b0, 1'b1, 1);
        checkCnt++; if (cyc - a < 3) $display("FAIL req_spacing: got %0d want >=3", cyc - a); else passCnt++;
        complete(3, 5, 1'b1, a);
    endtask

    task automatic test_stale_busy();
        int   a;
        logic bad;
        busA.IOACT = 1;
        tick(); tick(); tick();
        busA.CPUWE = 0; busA.CPULDS = 1; busA.CPUUDS = 1; busA.CPUREQ = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busA.IOREQ !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL stale_block: got IOREQ 1 want 0"); else passCnt++;
        busA.IOACT = 0;
        launch(1'b0, 1'b1, 1'b1, 3);
        complete(3, 4, 1'b1, a);
    endtask

    task automatic test_reset_in_act();
        int   a;
        logic bad;
        launch(1'b1, 1'b1, 1'b1, 1);
        tick(); tick();
        busA.IOACT = 1;
        tick(); tick(); tick(); tick();
        checkCnt++; if (busA.IOREQ !== 1'b0) $display("FAIL reach_act: got %b want 0", busA.IOREQ); else passCnt++;
        RES = 1;
        tick();
        checkCnt++; if (outA !== 7'b0000001) $display("FAIL reset_in_act: got %b want %b", outA, 7'b0000001); else passCnt++;
        sb.delete();  // aborted transaction produces neither ACK nor BERR
        RES = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busA.IOREQ !== 1'b0 || busA.ACK !== 1'b0 || busA.BERR !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL post_reset_block: got %b want no req/ack/berr", outA); else passCnt++;
        busA.IOACT = 0;
        launch(1'b1, 1'b1, 1'b1, 3);
        complete(3, 4, 1'b1, a);
    endtask

    task automatic test_timeout();
        int   n;
        logic bad;
        exp_t e;
        busB.CPUWE = 1; busB.CPULDS = 1; busB.CPUUDS = 1; busB.CPUREQ = 1;
        tick();
        checkCnt++; if (busB.IOREQ !== 1'b1) $display("FAIL to_launch: got %b want 1", busB.IOREQ); else passCnt++;
        obsStrb = {busB.IOWE, busB.IOLDS, busB.IOUDS};
        sb.push_back('{err: 1'b1, strb: 3'b111});
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busB.IOREQ !== 1'b1 || busB.BERR !== 1'b0 || busB.ACK !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL to_early: got %b want req held", outB); else passCnt++;
        tick();
        checkCnt++; if (outB !== 7'b0100001) $display("FAIL to_berr: got %b want %b", outB, 7'b0100001); else passCnt++;
        checkCnt++;
        if (sb.size() == 0) $display("FAIL sb_empty: got 0 entries want 1");
        else begin
            e = sb.pop_front();
            if (busB.BERR !== e.err || obsStrb !== e.strb)
                $display("FAIL to_sb: got berr %b strb %b want berr %b strb %b", busB.BERR, obsStrb, e.err, e.strb);
            else passCnt++;
        end
        tick();
        checkCnt++; if ({busB.ACK, busB.BERR} !== 2'b00) $display("FAIL to_pulse: got %b want 00", {busB.ACK, busB.BERR}); else passCnt++;
        busB.IOACT = 1; busB.CPUREQ = 0;
        tick(); tick();
        busB.CPUREQ = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busB.IOREQ !== 1'b0 || busB.ACK !== 1'b0) bad = 1;
        end
        checkCnt++; if (bad) $display("FAIL to_drain_block: got %b want no req", outB); else passCnt++;
        busB.IOACT = 0;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            if (n == 0) begin
                tick();
                if (busB.IOREQ === 1'b1) n = i;
            end
        end
        checkCnt++; if (n !== 3) $display("FAIL to_relaunch: got %0d want 3", n); else passCnt++;
        sb.push_back('{err: 1'b1, strb: 3'b111});
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (n == 0) begin
                tick();
                if (busB.BERR === 1'b1 || busB.ACK === 1'b1) n = i;
            end
        end
        checkCnt++; if (n !== 16 || busB.ACK !== 1'b0) $display("FAIL to_second: got %0d ack %b want 16 ack 0", n, busB.ACK); else passCnt++;
        if (sb.size() != 0) e = sb.pop_front();
        busB.CPUREQ = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_back_to_back();
        test_stale_busy();
        test_timeout();
        test_reset_in_act();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
